// File: rtl/ram16_fifo_ctrl_pkg.sv
// Shared constants for the RAM-based FIFO queues.
//   RAM16_DATA_WIDTH  : default word width
//   RAM16_DATA_DEPTH  : default address width (capacity = 2**depth words)
//   RAM16_AFULL_LEVEL : default almost_full threshold in words
//   fifo_capacity()   : capacity in words for a given address width (1 << depth)
package ram16_fifo_ctrl_pkg;

    localparam int RAM16_DATA_WIDTH  = 16;
    localparam int RAM16_DATA_DEPTH  = 4;
    localparam int RAM16_AFULL_LEVEL = 12;

    function automatic int fifo_capacity(input int depth);
        return 1 << depth;
    endfunction

endpackage

// File: rtl/ram16_fifo_ctrl_ram.sv
// Distributed RAM (myRAM_WxD_D style) used as FIFO storage.
// Synchronous write on the write port, asynchronous (combinational) read port.
// The write-side readback output (QW) of the original primitive is not needed by
// the FIFO and is not provided.
//   clk     : write clock
//   wr_en   : write enable (WE)
//   wr_addr : write address (AW)
//   wr_data : write data (D)
//   rd_addr : read address (AR)
//   rd_data : read data at rd_addr (QR), combinational
module ram16_fifo_ctrl_ram
    import ram16_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = RAM16_DATA_WIDTH,
    parameter int DATA_DEPTH = RAM16_DATA_DEPTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DATA_DEPTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_DEPTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:fifo_capacity(DATA_DEPTH)-1];

    // NOTE: the storage array has no reset; distributed RAM cannot be cleared in one
    // cycle, and the FIFO never exposes a word it has not written since the last clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ram16_fifo_ctrl.sv
// Synchronous FIFO sequencer around one distributed RAM instance.
// Owns write/read pointers, occupancy count and the valid/ready handshakes.
// Optional feature: define RAM16_FIFO_AFULL_EN to add the registered almost_full
// output and the AFULL_LEVEL parameter.
//   clk         : single clock, all state changes on posedge
//   nrst        : synchronous active-low reset (overrides flush and handshakes)
//   flush       : synchronous clear of contents (overrides write and pop)
//   wr_data     : write word
//   wr_valid    : producer has a word
//   wr_ready    : FIFO not full; write happens on wr_valid & wr_ready
//   rd_data     : head word, meaningful while rd_valid
//   rd_valid    : FIFO not empty
//   rd_ready    : consumer takes head; pop happens on rd_valid & rd_ready
//   level       : occupancy 0..2**DATA_DEPTH
//   almost_full : (RAM16_FIFO_AFULL_EN only) level >= AFULL_LEVEL, registered
module ram16_fifo_ctrl
    import ram16_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = RAM16_DATA_WIDTH,
    parameter int DATA_DEPTH  = RAM16_DATA_DEPTH
`ifdef RAM16_FIFO_AFULL_EN
    ,
    parameter int AFULL_LEVEL = RAM16_AFULL_LEVEL
`endif
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_DEPTH:0]   level
`ifdef RAM16_FIFO_AFULL_EN
    ,
    output logic                  almost_full
`endif
);

    localparam logic [DATA_DEPTH:0] CAPACITY = (DATA_DEPTH+1)'(fifo_capacity(DATA_DEPTH));
`ifdef RAM16_FIFO_AFULL_EN
    localparam logic [DATA_DEPTH:0] AFULL_THRESH = (DATA_DEPTH+1)'(AFULL_LEVEL);
`endif

    logic [DATA_DEPTH-1:0] wr_ptr;
    logic [DATA_DEPTH-1:0] rd_ptr;
    logic [DATA_DEPTH:0]   level_next;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  clear;

    // Handshakes depend only on the registered level, never on the peer's valid/ready,
    // so full+pop never writes and empty+write never pops.
    assign wr_ready = (level != CAPACITY);
    assign rd_valid = (level != '0);
    assign wr_fire  = wr_valid & wr_ready;
    assign rd_fire  = rd_valid & rd_ready;
    assign clear    = ~nrst | flush;

    // NOTE: every variable assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        level_next = level;
        if (wr_fire && !rd_fire) begin
            level_next = level + (DATA_DEPTH+1)'(1);
        end else if (rd_fire && !wr_fire) begin
            level_next = level - (DATA_DEPTH+1)'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
`ifdef RAM16_FIFO_AFULL_EN
            almost_full <= 1'b0;
`endif
        end else begin
            // Pointers wrap by natural binary overflow; full vs empty is told by level.
            if (wr_fire) begin
                wr_ptr <= wr_ptr + DATA_DEPTH'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + DATA_DEPTH'(1);
            end
            level <= level_next;
`ifdef RAM16_FIFO_AFULL_EN
            almost_full <= (level_next >= AFULL_THRESH);
`endif
        end
    end

    // A write suppressed by reset or flush must not touch the RAM either.
    ram16_fifo_ctrl_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire & ~clear),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ram16_fifo_ctrl.sv
// Self-checking bench for ram16_fifo_ctrl: a queue-based reference model plus
// directed scenarios with hand-computed expectations, then randomized traffic.
// Define RAM16_FIFO_AFULL_EN to also exercise almost_full.
module tb_ram16_fifo_ctrl;

    localparam int W   = 16;
    localparam int D   = 4;
    localparam int CAP = 16;
    localparam int AF  = 12;

    logic         clk      = 1'b0;
    logic         nrst     = 1'b0;
    logic         flush    = 1'b0;
    logic [W-1:0] wr_data  = '0;
    logic         wr_valid = 1'b0;
    logic         rd_ready = 1'b0;
    logic         wr_ready;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic [D:0]   level;
`ifdef RAM16_FIFO_AFULL_EN
    logic         almost_full;
    bit           model_af = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    logic [W-1:0] model_q[$];

    ram16_fifo_ctrl #(
        .DATA_WIDTH (W),
        .DATA_DEPTH (D)
`ifdef RAM16_FIFO_AFULL_EN
        ,
        .AFULL_LEVEL (AF)
`endif
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .flush    (flush),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .level    (level)
`ifdef RAM16_FIFO_AFULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue updated from the sampled inputs at each edge.
    always @(posedge clk) begin : model
        int sz;
        bit wf;
        bit pf;
        sz = model_q.size();
        if (!nrst || flush) begin
            model_q.delete();
        end else begin
            wf = wr_valid && (sz < CAP);
            pf = rd_ready && (sz > 0);
            if (pf) void'(model_q.pop_front());
            if (wf) model_q.push_back(wr_data);
        end
`ifdef RAM16_FIFO_AFULL_EN
        model_af = (model_q.size() >= AF);
`endif
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("level", 32'(level), 32'(model_q.size()));
            check("rd_valid", 32'(rd_valid), 32'(model_q.size() != 0));
            check("wr_ready", 32'(wr_ready), 32'(model_q.size() != CAP));
            if (model_q.size() != 0) check("rd_data", 32'(rd_data), 32'(model_q[0]));
`ifdef RAM16_FIFO_AFULL_EN
            check("almost_full", 32'(almost_full), 32'(model_af));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        rd_ready = 1'b0;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_flush();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
    endtask

    initial begin
        int wp;
        int rp;

        // Reset state
        nrst = 1'b0;
        tick();
        tick();
        nrst   = 1'b1;
        cmp_en = 1'b1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
`ifdef RAM16_FIFO_AFULL_EN
        check("rst_almost_full", 32'(almost_full), 32'd0);
`endif

        // Three words in, three words out, in order
        for (int i = 0; i < 3; i++) begin
            push(16'hA001 + 16'(i));
            check("t1_fill_level", 32'(level), 32'(i + 1));
        end
        check("t1_model_size", 32'(model_q.size()), 32'd3);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t1_head", 32'(rd_data), 32'(16'hA001 + 16'(i)));
            tick();
            check("t1_drain_level", 32'(level), 32'(2 - i));
        end
        rd_ready = 1'b0;
        check("t1_rd_valid_drop", 32'(rd_valid), 32'd0);

        // Fill to capacity; extra write ignored; full+pop only pops
        do_flush();
        for (int i = 0; i < CAP; i++) push(16'hB000 + 16'(i));
        check("t2_full_level", 32'(level), 32'd16);
        check("t2_full_wr_ready", 32'(wr_ready), 32'd0);
        push(16'hBEEF);
        check("t2_ignored_write", 32'(level), 32'd16);
        check("t2_first_word", 32'(rd_data), 32'hB000);
        wr_valid = 1'b1;
        wr_data  = 16'hBEEF;
        rd_ready = 1'b1;
        tick();
        check("t5_full_pop_level", 32'(level), 32'd15);
        check("t5_model_size", 32'(model_q.size()), 32'd15);
        wr_valid = 1'b0;
        for (int i = 1; i < CAP; i++) begin
            check("t2_drain_head", 32'(rd_data), 32'(16'hB000 + 16'(i)));
            tick();
        end
        rd_ready = 1'b0;
        check("t2_empty", 32'(level), 32'd0);

        // Steady state at level 8 with simultaneous write and pop across wrap
        do_flush();
        for (int i = 0; i < 8; i++) push(16'hC000 + 16'(i));
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'hC008 + 16'(i);
            rd_ready = 1'b1;
            check("t3_head", 32'(rd_data), 32'(16'hC000 + 16'(i)));
            tick();
            check("t3_level", 32'(level), 32'd8);
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;

        // Flush overrides concurrent write and pop
        do_flush();
        for (int i = 0; i < 5; i++) push(16'hD000 + 16'(i));
        check("t4_level5", 32'(level), 32'd5);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'hDEAD;
        rd_ready = 1'b1;
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("t4_flush_level", 32'(level), 32'd0);
        check("t4_flush_rd_valid", 32'(rd_valid), 32'd0);
        push(16'hD0FF);
        check("t4_post_flush_head", 32'(rd_data), 32'hD0FF);

`ifdef RAM16_FIFO_AFULL_EN
        // almost_full threshold, release on pop, clear on reset
        do_flush();
        for (int i = 0; i < 11; i++) push(16'hE000 + 16'(i));
        check("t6_af_at_11", 32'(almost_full), 32'd0);
        push(16'hE00B);
        check("t6_af_at_12", 32'(almost_full), 32'd1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("t6_af_after_pop", 32'(almost_full), 32'd0);
        push(16'hE00C);
        check("t6_af_refill", 32'(almost_full), 32'd1);
        nrst     = 1'b0;
        wr_valid = 1'b1;
        tick();
        nrst     = 1'b1;
        wr_valid = 1'b0;
        check("t6_af_reset", 32'(almost_full), 32'd0);
        check("t6_level_reset", 32'(level), 32'd0);
`endif

        // Randomized traffic with phases of varying write/read pressure
        for (int i = 0; i < 3000; i++) begin
            case ((i / 250) % 4)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                2:       begin wp = 95; rp = 95; end
                default: begin wp = 50; rp = 50; end
            endcase
            nrst     = ($urandom_range(0, 399) != 0);
            flush    = ($urandom_range(0, 149) == 0);
            wr_valid = ($urandom_range(0, 99) < wp);
            rd_ready = ($urandom_range(0, 99) < rp);
            wr_data  = W'($urandom);
            tick();
        end
        nrst     = 1'b1;
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
